// File: rtl/serial_adder_if.sv
// Handshake/data bundle for serial_adder_ctrl.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag OV.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             Co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             OV;

  modport master (output START, A, B, CI, input BUSY, DONE, S, Co, OV);
  modport slave  (input START, A, B, CI, output BUSY, DONE, S, Co, OV);
`else
  modport master (output START, A, B, CI, input BUSY, DONE, S, Co);
  modport slave  (input START, A, B, CI, output BUSY, DONE, S, Co);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first for WIDTH cycles under START/BUSY/DONE.
// Optional signed-overflow output OV is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic           CLOCK_50,
  input logic           RST_N,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             bit_sum;
  logic             carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ov_q, ov_d;
`endif

  assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ov_d    = ov_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (bus.START) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.CI;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = bit_sum;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = carry_nxt;
        cnt_d            = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          s_d     = res_d;
          co_d    = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB cell
          ov_d    = carry_q ^ carry_nxt;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ov_q    <= ov_d;
`endif
    end
  end

  assign bus.BUSY = (state_q == StShift);
  assign bus.DONE = (state_q == StDone);
  assign bus.S    = s_q;
  assign bus.Co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.OV   = ov_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8, 20 ns clock).
// OV checks are active when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] es, input logic eco,
                              input logic eov);
    check({tag, "_S"}, 32'(bus.S), 32'(es));
    check({tag, "_Co"}, 32'(bus.Co), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_OV"}, 32'(bus.OV), 32'(eov));
`else
    if (eov === 1'bz) $display("unused");
`endif
  endtask

  // One complete add: accept, 8 BUSY cycles, DONE pulse, then result held.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] es, input logic eco,
                         input logic eov);
    bus.A = a; bus.B = b; bus.CI = ci; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.CI = ~ci;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
      check({tag, "_nodone"}, 32'(bus.DONE), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(bus.DONE), 32'd1);
    check({tag, "_idle"}, 32'(bus.BUSY), 32'd0);
    check_result(tag, es, eco, eov);
    tick();
    check({tag, "_pulse"}, 32'(bus.DONE), 32'd0);
    check_result({tag, "_hold"}, es, eco, eov);
  endtask

  initial begin
    int          dones;
    logic [7:0]  ra, rb, rs;
    logic        rc, rco, rov;
    logic [8:0]  sum9;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.START = 1'b0; bus.A = '0; bus.B = '0; bus.CI = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check_result("rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    run_add("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("t2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // START while BUSY must be ignored
    bus.A = 8'h12; bus.B = 8'h34; bus.CI = 1'b0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    bus.A = 8'hAA; bus.B = 8'h55; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("t3_busy", 32'(bus.BUSY), 32'd1);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.DONE) dones++;
    end
    check("t3_dones", 32'(dones), 32'd1);
    check("t3_idle", 32'(bus.BUSY), 32'd0);
    check_result("t3", 8'h46, 1'b0, 1'b0);

    // START held through DONE: back-to-back accept
    bus.A = 8'h05; bus.B = 8'h06; bus.CI = 1'b0; bus.START = 1'b1;
    tick();
    bus.A = 8'h01; bus.B = 8'h02;
    for (int i = 0; i < 8; i++) tick();
    check("t4_done1", 32'(bus.DONE), 32'd1);
    check_result("t4_first", 8'h0B, 1'b0, 1'b0);
    tick();
    bus.START = 1'b0;
    check("t4_busy2", 32'(bus.BUSY), 32'd1);
    check("t4_nodone", 32'(bus.DONE), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("t4_done2", 32'(bus.DONE), 32'd1);
    check_result("t4_second", 8'h03, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-add
    bus.A = 8'h20; bus.B = 8'h21; bus.CI = 1'b0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    tick();
    #5 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(bus.BUSY), 32'd0);
    check("t5_done", 32'(bus.DONE), 32'd0);
    check_result("t5_rst", 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.DONE || bus.BUSY) dones++;
    end
    check("t5_noactivity", 32'(dones), 32'd0);
    run_add("t5_after", 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);

    // Signed-overflow corner cases
    run_add("t6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("t6b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add("t6c", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random operands against an integer model
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      sum9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rs  = sum9[7:0];
      rco = sum9[8];
      rov = (ra[7] == rb[7]) && (rs[7] != ra[7]);
      run_add("rand", ra, rb, rc, rs, rco, rov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
